// File: rtl/control_cursa.sv
// Race-level sequencer around the line-following motion logic: sensor sync/debounce,
// finish-line lap counting, per-circuit stop rules and gating of the driver commands.
module control_cursa #(
  parameter int DEBOUNCE_CYC = 50_000,
  parameter int BLANK_CYC    = 100_000_000,
  parameter int LOST_CYC     = 25_000_000,
  parameter int LAPS_CURVE   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] circuit,
  input  logic       senzor_1,
  input  logic       senzor_2,
  input  logic       senzor_3,
  input  logic       senzor_4,
  input  logic       senzor_5,
  input  logic [1:0] dir_in_A,
  input  logic [1:0] dir_in_B,
  output logic [1:0] directie_driverA,
  output logic [1:0] directie_driverB,
  output logic [7:0] count_ture,
  output logic [1:0] stare,
  output logic       lap_pulse,
  output logic       finished,
  output logic       line_lost
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DONE  = 2'b10,
    FAULT = 2'b11
  } state_t;

  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int BKW = $clog2(BLANK_CYC + 1);
  localparam int LSW = $clog2(LOST_CYC + 1);
  localparam logic [DBW-1:0] DB_LAST      = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [BKW-1:0] BLANK_LOAD   = BKW'(BLANK_CYC);
  localparam logic [LSW-1:0] LOST_LAST    = LSW'(LOST_CYC - 1);
  localparam logic [7:0]     CURVE_TARGET = 8'(LAPS_CURVE);

  state_t         state, state_nxt;
  logic [6:0]     sync_1, sync_2;
  logic           s1, s2, s3, s4, s5, start_s, abort_s;
  logic           start_prev, abort_prev;
  logic           start_edge, abort_edge, start_run;
  logic           mark, mdb, mdb_prev, lap_ev;
  logic [DBW-1:0] db_cnt;
  logic [BKW-1:0] blank_cnt;
  logic [LSW-1:0] lost_cnt, lost_nxt;
  logic [1:0]     circuit_q, circuit_nxt;
  logic [7:0]     count_nxt, lap_count, target;
  logic           pulse_nxt;
  logic           sensors_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1     <= '0;
      sync_2     <= '0;
      start_prev <= 1'b0;
      abort_prev <= 1'b0;
    end else begin
      sync_1     <= {start, abort, senzor_5, senzor_4, senzor_3, senzor_2, senzor_1};
      sync_2     <= sync_1;
      start_prev <= start_s;
      abort_prev <= abort_s;
    end
  end

  assign {start_s, abort_s, s5, s4, s3, s2, s1} = sync_2;
  assign start_edge = start_s & ~start_prev;
  assign abort_edge = abort_s & ~abort_prev;
  // Side sensors 2 and 4 only steer the motion logic; they have no race-level role here.
  assign sensors_unused = s2 ^ s4;

  assign mark = s1 & s5;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdb      <= 1'b0;
      mdb_prev <= 1'b0;
      db_cnt   <= '0;
    end else begin
      mdb_prev <= mdb;
      if (mark != mdb) begin
        if (db_cnt == DB_LAST) begin
          mdb    <= mark;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign lap_ev    = mdb & ~mdb_prev & (blank_cnt == '0);
  assign start_run = (state == IDLE) && start_edge && !abort_edge && (circuit != 2'b00);

  // Blanking runs in every state so a mark seen just before start still shadows the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_cnt <= '0;
    end else if (start_run || lap_ev) begin
      blank_cnt <= BLANK_LOAD;
    end else if (blank_cnt != '0) begin
      blank_cnt <= blank_cnt - 1'b1;
    end
  end

  always_comb begin
    lap_count = (count_ture == 8'hFF) ? 8'hFF : count_ture + 8'd1;
    case (circuit_q)
      2'b01:   target = 8'd1;
      2'b10:   target = CURVE_TARGET;
      default: target = 8'd0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count_ture;
    pulse_nxt   = 1'b0;
    lost_nxt    = '0;
    circuit_nxt = circuit_q;
    unique case (state)
      IDLE: begin
        if (circuit == 2'b00) count_nxt = 8'd0;
        if (start_run) begin
          state_nxt   = RUN;
          count_nxt   = 8'd0;
          circuit_nxt = circuit;
        end
      end
      RUN: begin
        if (lap_ev) begin
          count_nxt = lap_count;
          pulse_nxt = 1'b1;
        end
        lost_nxt = s3 ? '0 : lost_cnt + 1'b1;
        // Abort beats target, target beats line loss; a lap in that cycle is still counted.
        if (abort_edge)
          state_nxt = IDLE;
        else if (lap_ev && (target != 8'd0) && (lap_count == target))
          state_nxt = DONE;
        else if (!s3 && (lost_cnt == LOST_LAST))
          state_nxt = FAULT;
      end
      DONE, FAULT: begin
        if (abort_edge || start_edge) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      count_ture       <= 8'd0;
      lap_pulse        <= 1'b0;
      lost_cnt         <= '0;
      circuit_q        <= 2'b00;
      directie_driverA <= 2'b00;
      directie_driverB <= 2'b00;
    end else begin
      state      <= state_nxt;
      count_ture <= count_nxt;
      lap_pulse  <= pulse_nxt;
      lost_cnt   <= lost_nxt;
      circuit_q  <= circuit_nxt;
      if (state == RUN) begin
        directie_driverA <= dir_in_A;
        directie_driverB <= dir_in_B;
      end else begin
        directie_driverA <= 2'b00;
        directie_driverB <= 2'b00;
      end
    end
  end

  assign stare     = state;
  assign finished  = (state == DONE);
  assign line_lost = (state == FAULT);

endmodule

// File: tb/tb_control_cursa.sv
// Self-checking bench for control_cursa: mark table plus hand sequences, lap pulses
// checked against a scoreboard of expected (cycle, count) pairs.
module tb_control_cursa;

  localparam int DB          = 4;
  localparam int BLANK       = 20;
  localparam int LOST        = 10;
  localparam int CURVE_LAPS  = 10;
  localparam int LAP_LATENCY = 2 + DB + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] circuit = 2'b00;
  logic       senzor_1 = 1'b0, senzor_2 = 1'b0, senzor_3 = 1'b1, senzor_4 = 1'b0, senzor_5 = 1'b0;
  logic [1:0] dir_in_A = 2'b01;
  logic [1:0] dir_in_B = 2'b10;
  logic [1:0] directie_driverA, directie_driverB;
  logic [7:0] count_ture;
  logic [1:0] stare;
  logic       lap_pulse, finished, line_lost;

  control_cursa #(
    .DEBOUNCE_CYC(DB),
    .BLANK_CYC(BLANK),
    .LOST_CYC(LOST),
    .LAPS_CURVE(CURVE_LAPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .circuit(circuit),
    .senzor_1(senzor_1), .senzor_2(senzor_2), .senzor_3(senzor_3),
    .senzor_4(senzor_4), .senzor_5(senzor_5),
    .dir_in_A(dir_in_A), .dir_in_B(dir_in_B),
    .directie_driverA(directie_driverA), .directie_driverB(directie_driverB),
    .count_ture(count_ture), .stare(stare), .lap_pulse(lap_pulse),
    .finished(finished), .line_lost(line_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due_cyc; int count; } lap_exp_t;
  typedef struct { int high_len; int gap; bit expect_lap; } mark_vec_t;
  typedef struct { logic [1:0] a; logic [1:0] b; } dir_vec_t;

  lap_exp_t  lap_q[$];
  lap_exp_t  mon_e;
  mark_vec_t race_tab[6];
  mark_vec_t clean_mark;
  dir_vec_t  dir_tab[4];
  int tests_run = 0;
  int tests_failed = 0;
  int exp_count = 0;
  int target = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one finish mark; a lap that should count is queued with its due cycle and count.
  task automatic applyStimulus(input mark_vec_t v);
    lap_exp_t e;
    senzor_1 = 1'b1;
    senzor_5 = 1'b1;
    if (v.expect_lap) begin
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      e.due_cyc = cyc + LAP_LATENCY;
      e.count   = exp_count;
      lap_q.push_back(e);
    end
    tick(v.high_len);
    senzor_1 = 1'b0;
    senzor_5 = 1'b0;
    tick(v.gap);
  endtask

  function automatic int exp_state();
    return (target != 0 && exp_count == target) ? 2 : 1;
  endfunction

  task automatic press_start_run(input logic [1:0] circ, input int tgt);
    circuit = circ;
    start = 1'b1;
    tick(3);
    start = 1'b0;
    exp_count = 0;
    target = tgt;
    tick(2);
    checkOutput("run_entered", stare, 1);
    checkOutput("run_count_cleared", count_ture, 0);
    tick(BLANK + 5);
  endtask

  task automatic press_start_only();
    start = 1'b1;
    tick(3);
    start = 1'b0;
    tick(2);
  endtask

  task automatic press_abort();
    abort = 1'b1;
    tick(3);
    abort = 1'b0;
    tick(2);
  endtask

  always @(negedge clk) begin
    if (rst_n && lap_pulse) begin
      if (lap_q.size() == 0) begin
        checkOutput("unexpected_lap_pulse", lap_pulse, 0);
      end else begin
        mon_e = lap_q.pop_front();
        checkOutput("lap_pulse_cycle", cyc, mon_e.due_cyc);
        checkOutput("lap_count", count_ture, mon_e.count);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    race_tab[0] = '{3, 27, 1'b0};
    race_tab[1] = '{6, 24, 1'b1};
    race_tab[2] = '{6, 4,  1'b1};
    race_tab[3] = '{6, 9,  1'b0};
    race_tab[4] = '{6, 24, 1'b1};
    race_tab[5] = '{2, 28, 1'b0};
    clean_mark  = '{6, 24, 1'b1};
    dir_tab[0]  = '{2'b01, 2'b10};
    dir_tab[1]  = '{2'b10, 2'b01};
    dir_tab[2]  = '{2'b11, 2'b00};
    dir_tab[3]  = '{2'b01, 2'b10};

    tick(2);
    checkOutput("reset_stare", stare, 0);
    checkOutput("reset_count", count_ture, 0);
    checkOutput("reset_drvA", directie_driverA, 0);
    checkOutput("reset_drvB", directie_driverB, 0);
    checkOutput("reset_flags", {lap_pulse, finished, line_lost}, 0);
    rst_n = 1'b1;
    tick(3);

    circuit = 2'b00;
    press_start_only();
    checkOutput("start_ignored_circ00", stare, 0);
    checkOutput("idle_drvA_gated", directie_driverA, 0);

    // Curves circuit: ten clean laps, DONE on the tenth, drivers follow only in RUN.
    press_start_run(2'b10, CURVE_LAPS);
    for (int i = 0; i < 4; i++) begin
      dir_in_A = dir_tab[i].a;
      dir_in_B = dir_tab[i].b;
      tick(1);
      checkOutput("run_drvA", directie_driverA, dir_tab[i].a);
      checkOutput("run_drvB", directie_driverB, dir_tab[i].b);
    end
    for (int i = 0; i < CURVE_LAPS; i++) begin
      applyStimulus(clean_mark);
      checkOutput("curve_state", stare, exp_state());
    end
    checkOutput("curve_finished", finished, 1);
    checkOutput("curve_count", count_ture, 10);
    checkOutput("done_drvA", directie_driverA, 0);
    checkOutput("done_drvB", directie_driverB, 0);
    press_start_only();
    checkOutput("done_to_idle", stare, 0);

    // Endurance: glitch rejection and lap blanking from the mark table, then abort.
    press_start_run(2'b11, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(race_tab[i]);
      checkOutput("table_state", stare, exp_state());
    end
    checkOutput("table_count", count_ture, 3);
    press_abort();
    checkOutput("abort_idle", stare, 0);
    checkOutput("abort_count_held", count_ture, 3);
    checkOutput("pending_laps_a", lap_q.size(), 0);

    // Straight circuit latched at start; changing circuit mid-run must not matter.
    press_start_run(2'b01, 1);
    circuit = 2'b11;
    tick(2);
    applyStimulus(clean_mark);
    checkOutput("straight_done", stare, 2);
    checkOutput("straight_count", count_ture, 1);
    press_start_only();
    checkOutput("straight_idle", stare, 0);

    // Line lost: nine low cycles survive, ten trip FAULT.
    press_start_run(2'b11, 0);
    senzor_3 = 1'b0;
    tick(LOST - 1);
    senzor_3 = 1'b1;
    tick(5);
    checkOutput("lost9_still_run", stare, 1);
    senzor_3 = 1'b0;
    tick(LOST);
    senzor_3 = 1'b1;
    tick(4);
    checkOutput("lost10_fault", stare, 3);
    checkOutput("lost10_line_lost", line_lost, 1);
    checkOutput("fault_drvA", directie_driverA, 0);
    press_start_only();
    checkOutput("fault_to_idle", stare, 0);
    checkOutput("fault_cleared", line_lost, 0);

    // Abort arriving in the same cycle as the tenth curve lap.
    press_start_run(2'b10, CURVE_LAPS);
    for (int i = 0; i < CURVE_LAPS - 1; i++) applyStimulus(clean_mark);
    senzor_1 = 1'b1;
    senzor_5 = 1'b1;
    exp_count = exp_count + 1;
    mon_e.due_cyc = cyc + LAP_LATENCY;
    mon_e.count   = exp_count;
    lap_q.push_back(mon_e);
    tick(4);
    abort = 1'b1;
    tick(2);
    senzor_1 = 1'b0;
    senzor_5 = 1'b0;
    tick(2);
    abort = 1'b0;
    tick(20);
    checkOutput("abort_lap_idle", stare, 0);
    checkOutput("abort_lap_count", count_ture, 10);
    checkOutput("abort_lap_not_done", finished, 0);
    circuit = 2'b00;
    tick(2);
    checkOutput("idle_circ00_clear", count_ture, 0);

    // Saturation at 255, then reset asserted mid-run.
    press_start_run(2'b11, 0);
    for (int i = 0; i < 256; i++) applyStimulus(clean_mark);
    checkOutput("saturated_count", count_ture, 255);
    checkOutput("pending_laps_b", lap_q.size(), 0);
    senzor_1 = 1'b1;
    senzor_5 = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #2;
    checkOutput("midrun_reset_stare", stare, 0);
    checkOutput("midrun_reset_count", count_ture, 0);
    checkOutput("midrun_reset_drv", {directie_driverA, directie_driverB}, 0);
    checkOutput("midrun_reset_flags", {lap_pulse, finished, line_lost}, 0);
    senzor_1 = 1'b0;
    senzor_5 = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(30);
    checkOutput("post_reset_count", count_ture, 0);
    checkOutput("pending_laps_c", lap_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
